band_pulse_array: RTL
=====================

# band_pulse_array

Multi-channel, parametrised successor of the single-antenna band pulse block. For each of `N_CH` antenna band inputs it:
- stretches hits to a fixed width, with a selectable retrigger mode;
- keeps a freezable hit-history shift register;
- snapshots that history on a trigger-sequencer code;
- counts accepted pulses per one-second window with saturation.

It sits between the band discriminators and the station trigger/readout logic and replaces per-antenna instances.

## Interface
Parameters:
- `N_CH`, 8, number of antenna channels
- `HIST_DEPTH`, 24, history bits per channel (≤ 31)
- `STRETCH`, 20, stretched pulse width in clk_r2 cycles (1..63)
- `RETRIG`, 0, 0 = non-retriggerable, 1 = retriggerable stretch
- `CNT_W`, 24, rate counter width
- `TAP_TRIG`, 1, history tap driving `ant_trig`
- `TAP_PAT`, 4, history tap driving `ant_pat`
- `FRZ_LO`, 1, freeze when `trigger_shifter` > `FRZ_LO`
- `FRZ_HI`, 4, and `trigger_shifter` ≤ `FRZ_HI`
- `SNAP_CODE`, 3, `trigger_shifter` value that captures the history

Ports:
- `clk_r2` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low; all state cleared while low
- `ant_in` in N_CH: band hit inputs, already synchronous to clk_r2
- `mask` in N_CH: per-channel enable, gates `ant_trig`/`ant_pat` only
- `trigger_shifter` in 4: trigger sequencer state code
- `window_msb` in 1: MSB of the shared 1 MHz second counter (count_1M[23])
- `ant_trig` out N_CH: `hist[TAP_TRIG] & mask`, per channel
- `ant_pat` out N_CH: `hist[TAP_PAT] & mask`, per channel
- `band_pattern` out N_CH*HIST_DEPTH: snapshot history; channel c occupies bits [c*HIST_DEPTH +: HIST_DEPTH]
- `rate` out N_CH*CNT_W: last-window pulse count; channel c occupies bits [c*CNT_W +: CNT_W]
- `rate_sat` out N_CH: the channel's last-window count saturated
- `rate_valid` out 1: one-cycle strobe when `rate` updates

## Operation
- **Edge detect:** `ant_q` is `ant_in` registered. A rising event is `ant_in & ~ant_q`. A held-high input produces one event.
- **Stretch:** each channel has a 6-bit down-counter `sc` and output `st = (sc != 0)`.
  - Event while `sc == 0`: load `sc = STRETCH`. This is an accepted pulse.
  - Event while `sc != 0`:
    - `RETRIG=0`: ignored; not counted.
    - `RETRIG=1`: reload `STRETCH`; not counted as a new pulse.
  - Otherwise, when `sc != 0`, decrement.
- **History:** `hist[0] <= st` and `hist[k] <= hist[k-1]`, except in freeze.
  - Freeze means `FRZ_LO < trigger_shifter ≤ FRZ_HI`. All history bits, including bit 0, hold during freeze.
  - Stretch and counting continue during freeze.
- **Snapshot:** when `trigger_shifter == SNAP_CODE`, `band_pattern` slice <= `hist[HIST_DEPTH-1:0]`. It is reloaded every cycle the code persists and holds otherwise.
- **Rate window:** `window_msb` is registered twice (`w1`, `w2`).
  - The boundary is `w1 & ~w2`, i.e. an MSB rising edge.
  - On the boundary, per channel: `rate <= sat(cnt + acc)` and `rate_sat <= overflow`. `cnt <= 0` in the same cycle. `rate_valid` pulses.
  - `acc` is an accepted pulse in that cycle. No pulse is lost or double-counted across the boundary.
  - Otherwise `cnt` increments per accepted pulse and saturates at 2^CNT_W−1. Once saturated it holds until the boundary.
- **Mask:** does not affect counting or history. Counting and history see unmasked activity.

## Timing
- Reset values: every output is 0, and all internal state (`ant_q`, `sc`, `hist`, `cnt`, `w1`, `w2`) is 0.
- Deassertion of `reset` is synchronised externally. The first clock after release behaves as an idle cycle.
- Pulse latency: `ant_in` is sampled high at edge E0 with `ant_q = 0`.
  - `st` is high E0..E0+STRETCH−1 (STRETCH cycles).
  - `hist[0]` rises at E1.
  - `ant_trig` rises at E1+TAP_TRIG; `ant_pat` rises at E1+TAP_PAT (no freeze).
- Rate latency: `window_msb` rises before edge W0.
  - `rate`/`rate_valid` update at W0+1 and `rate_valid` is high one cycle.
  - `window_msb` falling has no effect.
- Simultaneous freeze and snapshot (default codes) captures the frozen history.
- Reset asserted mid-pulse or mid-window clears immediately. No `rate_valid` is issued for the partial window.

## Structure
- Package `band_pulse_pkg`:
  - parameter defaults;
  - function `in_freeze(code, lo, hi)`;
  - saturating-increment function;
  - stretch counter width constant (6).
- Sub-module `band_pulse_chan`: one channel's edge detect, stretch, history, counter and snapshot. It is instantiated N_CH times by generate.
- The top level holds the window edge detector, the freeze/snapshot decode (shared), and the output packing.

## Test plan
- **Single pulse:** 3-cycle hit on ch0, RETRIG=0, STRETCH=20. `st` high exactly 20 cycles; `ant_trig[0]` high E2..E21; `cnt` = 1.
- **Retrigger:** second event at E10.
  - RETRIG=0: `st` ends at E19; `cnt` = 1.
  - RETRIG=1: `st` extended to end at E29; `cnt` = 1.
- **Freeze:** `trigger_shifter` = 2,3,4 for 3 cycles mid-pulse. History holds for 3 cycles. `band_pattern` equals the history captured at code 3. `ant_pat` delayed by 3 cycles.
- **Window boundary:**
  - 5 pulses, then `window_msb` 0→1 with a 6th accepted pulse in the boundary cycle: `rate` = 6, `rate_valid` one cycle, next-window `cnt` starts at 0.
  - `window_msb` 1→0: no strobe.
- **Saturation:** CNT_W=4, 20 pulses in one window. `rate` = 15 and `rate_sat` = 1. Next window with 2 pulses: `rate` = 2, `rate_sat` = 0.
- **Mask/reset:** `mask[1]` = 0 with hits: `ant_trig[1]` = 0 but `rate[1]` counts. Async `reset` low mid-pulse: all outputs 0 within the same cycle.

Source files
------------

// File: rtl/band_pulse_pkg.sv
// Shared defaults, constants and helpers for the multi-channel band pulse array.
// The rate counter width must be at most 32 bits.
package band_pulse_pkg;

   localparam int N_CH_DEF       = 8;
   localparam int HIST_DEPTH_DEF = 24;
   localparam int STRETCH_DEF    = 20;
   localparam int RETRIG_DEF     = 0;
   localparam int CNT_W_DEF      = 24;
   localparam int TAP_TRIG_DEF   = 1;
   localparam int TAP_PAT_DEF    = 4;
   localparam int FRZ_LO_DEF     = 1;
   localparam int FRZ_HI_DEF     = 4;
   localparam int SNAP_CODE_DEF  = 3;

   localparam int SC_W = 6;

   function automatic logic in_freeze(input logic [3:0] code, input int lo, input int hi);
      int c;
      c = {28'd0, code};
      return (c > lo) && (c <= hi);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc,
                                           input logic [31:0] max);
      if (inc && (v < max)) return v + 32'd1;
      return v;
   endfunction

endpackage

// File: rtl/band_pulse_chan.sv
// One antenna channel: edge detect, pulse stretch, freezable history,
// trigger snapshot and the per-window saturating pulse counter.
module band_pulse_chan
   import band_pulse_pkg::*;
#(
   parameter int HIST_DEPTH = HIST_DEPTH_DEF,
   parameter int STRETCH    = STRETCH_DEF,
   parameter int RETRIG     = RETRIG_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int TAP_TRIG   = TAP_TRIG_DEF,
   parameter int TAP_PAT    = TAP_PAT_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ant_i,
   input  logic                  mask_i,
   input  logic                  freeze_i,
   input  logic                  snap_i,
   input  logic                  bnd_i,
   output logic                  trig_o,
   output logic                  pat_o,
   output logic [HIST_DEPTH-1:0] pattern_o,
   output logic [CNT_W-1:0]      rate_o,
   output logic                  sat_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                  ant_q;
   logic [SC_W-1:0]       sc_q, sc_d;
   logic [HIST_DEPTH-1:0] hist_q, hist_d, pat_q, pat_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, rate_q, rate_d;
   logic                  sat_q, sat_d;
   logic                  ev, st, acc;

   always_comb begin
      ev     = ant_i & ~ant_q;
      st     = (sc_q != '0);
      acc    = ev & ~st;
      sc_d   = sc_q;
      hist_d = hist_q;
      pat_d  = pat_q;
      cnt_d  = cnt_q;
      rate_d = rate_q;
      sat_d  = sat_q;
      // A retrigger reloads the width but is never counted as a new pulse.
      if (ev && (!st || (RETRIG != 0))) sc_d = SC_W'(STRETCH);
      else if (st)                      sc_d = sc_q - 1'b1;
      if (!freeze_i) hist_d = {hist_q[HIST_DEPTH-2:0], st};
      if (snap_i)    pat_d  = hist_q;
      if (bnd_i) begin
         rate_d = CNT_W'(sat_inc(32'(cnt_q), acc, 32'(CNT_MAX)));
         sat_d  = (rate_d == CNT_MAX);
         cnt_d  = '0;
      end else begin
         cnt_d  = CNT_W'(sat_inc(32'(cnt_q), acc, 32'(CNT_MAX)));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ant_q  <= 1'b0;
         sc_q   <= '0;
         hist_q <= '0;
         pat_q  <= '0;
         cnt_q  <= '0;
         rate_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         ant_q  <= ant_i;
         sc_q   <= sc_d;
         hist_q <= hist_d;
         pat_q  <= pat_d;
         cnt_q  <= cnt_d;
         rate_q <= rate_d;
         sat_q  <= sat_d;
      end
   end

   assign trig_o    = hist_q[TAP_TRIG] & mask_i;
   assign pat_o     = hist_q[TAP_PAT] & mask_i;
   assign pattern_o = pat_q;
   assign rate_o    = rate_q;
   assign sat_o     = sat_q;

endmodule

// File: rtl/band_pulse_array.sv
// N_CH-channel band pulse block: shared window edge detect and trigger-code
// decode feeding one band_pulse_chan per antenna, with packed outputs.
module band_pulse_array
   import band_pulse_pkg::*;
#(
   parameter int N_CH       = N_CH_DEF,
   parameter int HIST_DEPTH = HIST_DEPTH_DEF,
   parameter int STRETCH    = STRETCH_DEF,
   parameter int RETRIG     = RETRIG_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int TAP_TRIG   = TAP_TRIG_DEF,
   parameter int TAP_PAT    = TAP_PAT_DEF,
   parameter int FRZ_LO     = FRZ_LO_DEF,
   parameter int FRZ_HI     = FRZ_HI_DEF,
   parameter int SNAP_CODE  = SNAP_CODE_DEF
) (
   input  logic                       clk_r2,
   input  logic                       reset,
   input  logic [N_CH-1:0]            ant_in,
   input  logic [N_CH-1:0]            mask,
   input  logic [3:0]                 trigger_shifter,
   input  logic                       window_msb,
   output logic [N_CH-1:0]            ant_trig,
   output logic [N_CH-1:0]            ant_pat,
   output logic [N_CH*HIST_DEPTH-1:0] band_pattern,
   output logic [N_CH*CNT_W-1:0]      rate,
   output logic [N_CH-1:0]            rate_sat,
   output logic                       rate_valid
);

   logic w1_q, w2_q, valid_q;
   logic bnd, freeze, snap;

   always_ff @(posedge clk_r2 or negedge reset) begin
      if (!reset) begin
         w1_q    <= 1'b0;
         w2_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         w1_q    <= window_msb;
         w2_q    <= w1_q;
         valid_q <= bnd;
      end
   end

   // Only a rising MSB closes a window; the falling half-second is ignored.
   assign bnd        = w1_q & ~w2_q;
   assign freeze     = in_freeze(trigger_shifter, FRZ_LO, FRZ_HI);
   assign snap       = (trigger_shifter == 4'(SNAP_CODE));
   assign rate_valid = valid_q;

   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      band_pulse_chan #(
         .HIST_DEPTH(HIST_DEPTH),
         .STRETCH   (STRETCH),
         .RETRIG    (RETRIG),
         .CNT_W     (CNT_W),
         .TAP_TRIG  (TAP_TRIG),
         .TAP_PAT   (TAP_PAT)
      ) u_chan (
         .clk_i    (clk_r2),
         .rst_ni   (reset),
         .ant_i    (ant_in[c]),
         .mask_i   (mask[c]),
         .freeze_i (freeze),
         .snap_i   (snap),
         .bnd_i    (bnd),
         .trig_o   (ant_trig[c]),
         .pat_o    (ant_pat[c]),
         .pattern_o(band_pattern[c*HIST_DEPTH +: HIST_DEPTH]),
         .rate_o   (rate[c*CNT_W +: CNT_W]),
         .sat_o    (rate_sat[c])
      );
   end

endmodule
